multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM of the RV32I multicycle core; sits directly upstream of the register file and drives its `reg_write` strobe.
- Also drives the selects for write-data and ALU operands.
- Decodes `opcode`/`funct3`/`funct7[5]` from the instruction register and sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Evaluates branch conditions from ALU flags.

Parameters:
- RESET_CHECK, 1, when 1 all write enables are forced to 0 while `rst` is high.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction bits [6:0] from IR.
- funct3  in  3  instruction bits [14:12].
- funct7_b5  in  1  instruction bit 30.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed A < B.
- alu_ltu  in  1  unsigned A < B.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data-memory write strobe.
- ir_write  out  1  IR and oldPC load enable.
- reg_write  out  1  regfile write enable.
- result_src  out  2  writeback/PC source: 00 = ALUOut, 01 = MDR, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 latch.
- alu_src_b  out  2  ALU B select: 00 = rs2 latch, 01 = imm, 10 = const 4.
- alu_ctrl  out  4  ALU operation code (encoding under Behaviour).
- jalr_mask  out  1  datapath clears bit 0 of PC write data.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  sticky illegal-instruction flag.

Behaviour:
- Reset (synchronous): state <= FETCH; illegal <= 0.
- While `rst` is high: `pc_write`, `ir_write`, `mem_write`, `reg_write` and `retire` are 0.
- Outputs are Moore (decoded from state). Exceptions are BRANCH `pc_write` and the `alu_ctrl` decode, which also depend on inputs.
- Unlisted outputs are 0 in every state.
- alu_ctrl encoding: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASSB.

States and transitions:
- FETCH: adr_src=0, ir_write=1, a=00, b=10, ADD, result_src=10, pc_write=1 -> DECODE.
- DECODE: a=01, b=01, ADD (ALUOut <= oldPC+imm). Next state by opcode:
  - 0000011 / 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH if funct3 ∉ {010, 011}, else ILLEGAL.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - 0010111 -> ALUWB (AUIPC).
  - 0001111 -> FETCH with retire=1 (FENCE as no-op).
  - anything else (including 1110011) -> ILLEGAL.
- MEMADR: a=10, b=01, ADD -> MEMREAD if opcode is a load, MEMWRITE if a store.
- MEMREAD: adr_src=1 -> MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1, retire=1 -> FETCH.
- EXECR: a=10, b=00 -> ALUWB. alu_ctrl by funct3:
  - 000: SUB if funct7_b5, else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if funct7_b5, else SRL.
  - 110 OR, 111 AND.
- EXECI: a=10, b=01 -> ALUWB. Same decode as EXECR, except funct3=000 is always ADD; funct7_b5 is used only when funct3=101.
- ALUWB: result_src=00, reg_write=1, retire=1 -> FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00, retire=1 -> FETCH. pc_write=take, where take by funct3:
  - 000 zero, 001 !zero.
  - 100 lt, 101 !lt.
  - 110 ltu, 111 !ltu.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1 -> ALUWB. PC <= target held in ALUOut; ALUOut <= oldPC+4.
- JALR: a=10, b=01, ADD, result_src=10, jalr_mask=1, pc_write=1 -> LINK.
- LINK: a=01, b=10, ADD -> ALUWB.
- LUI: b=01, PASSB -> ALUWB.
- ILLEGAL: illegal=1, all enables 0; remains in ILLEGAL until `rst`.

Cycle counts:
- Load 5; store 4; R/I-type 4; branch 3; JAL 4; JALR 5; LUI 4; AUIPC 3; FENCE 2.

Boundary conditions:
- Reset asserted mid-instruction aborts it: no `reg_write`/`mem_write` in the reset cycle, FETCH on the next cycle.
- `retire` is never asserted together with `illegal`.

Test Plan:
- Reset held 2 cycles, then ADD x3 (0110011, f3=000, b5=0) -> states FETCH, DECODE, EXECR (alu_ctrl=0000), ALUWB. reg_write=1 only in cycle 4; retire once.
- LW (0000011) -> 5 cycles. adr_src=1 in MEMREAD; MEMWB has result_src=01 and reg_write=1; mem_write stays 0.
- SW (0100011) -> 4 cycles. mem_write=1 exactly once in cycle 4; reg_write never asserted.
- BNE f3=001: alu_zero=1 -> pc_write=0 in BRANCH. Repeat with alu_zero=0 -> pc_write=1. BLTU with alu_ltu=1 -> pc_write=1.
- JALR -> JALR state shows pc_write=1, jalr_mask=1, result_src=10. LINK follows with a=01, b=10. ALUWB shows reg_write=1; total 5 cycles.
- Opcode 1110011 -> ILLEGAL entered after DECODE; illegal=1 held for 20 cycles with no enables. rst=1 for 1 cycle -> illegal=0, FETCH resumes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the RV32I multicycle core: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write strobes, branch resolution, retire and the sticky illegal flag.
module multicycle_ctrl #(
    parameter bit RESET_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic       jalr_mask,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // funct7_b5 selects SUB only for register-register ops; it selects SRA for both forms.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b5, input logic is_reg);
        case (f3)
            3'b000:  alu_decode = (is_reg && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    function automatic logic branch_take(input logic [2:0] f3, input logic zero, input logic lt,
                                         input logic ltu);
        case (f3)
            3'b000:  branch_take = zero;
            3'b001:  branch_take = ~zero;
            3'b100:  branch_take = lt;
            3'b101:  branch_take = ~lt;
            3'b110:  branch_take = ltu;
            3'b111:  branch_take = ~ltu;
            default: branch_take = 1'b0;
        endcase
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic       illegal_r;
    logic       hold_s;
    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [3:0] alu_ctrl_s;
    logic       jalr_mask_s;
    logic       retire_s;

    // State register and sticky illegal flag (set on the same edge ILLEGAL is entered)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            illegal_r <= illegal_r | (state_next_s == S_ILLEGAL);
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_next_s = state_r;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_ctrl_s   = ALU_ADD;
        jalr_mask_s  = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                pc_write_s   = 1'b1;
                state_next_s = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                    OP_REG:            state_next_s = S_EXECR;
                    OP_IMM:            state_next_s = S_EXECI;
                    OP_BRANCH:         state_next_s = (funct3 == 3'b010 || funct3 == 3'b011) ?
                                                      S_ILLEGAL : S_BRANCH;
                    OP_JAL:            state_next_s = S_JAL;
                    OP_JALR:           state_next_s = S_JALR;
                    OP_LUI:            state_next_s = S_LUI;
                    OP_AUIPC:          state_next_s = S_ALUWB;
                    OP_FENCE: begin
                        retire_s     = 1'b1;
                        state_next_s = S_FETCH;
                    end
                    default:           state_next_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                state_next_s = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_s    = 1'b1;
                state_next_s = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_s  = 2'b10;
                alu_ctrl_s   = alu_decode(funct3, funct7_b5, 1'b1);
                state_next_s = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                alu_ctrl_s   = alu_decode(funct3, funct7_b5, 1'b0);
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s  = 2'b10;
                alu_ctrl_s   = ALU_SUB;
                pc_write_s   = branch_take(funct3, alu_zero, alu_lt, alu_ltu);
                retire_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target already in ALUOut while the ALU forms the link address
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                pc_write_s   = 1'b1;
                state_next_s = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                jalr_mask_s  = 1'b1;
                pc_write_s   = 1'b1;
                state_next_s = S_LINK;
            end
            S_LINK: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                state_next_s = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b_s  = 2'b01;
                alu_ctrl_s   = ALU_PASSB;
                state_next_s = S_ALUWB;
            end
            S_ILLEGAL: begin
                state_next_s = S_ILLEGAL;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    assign hold_s     = RESET_CHECK && rst;
    assign pc_write   = pc_write_s  & ~hold_s;
    assign ir_write   = ir_write_s  & ~hold_s;
    assign mem_write  = mem_write_s & ~hold_s;
    assign reg_write  = reg_write_s & ~hold_s;
    assign retire     = retire_s    & ~rst;
    assign adr_src    = adr_src_s;
    assign result_src = result_src_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign alu_ctrl   = alu_ctrl_s;
    assign jalr_mask  = jalr_mask_s;
    assign illegal    = illegal_r;

endmodule
